ssm_group_accum: RTL and testbench

- Group-accumulation and skip-add stage behind the per-tile N-reduction in the SSM datapath.
- Sums a runtime-configurable number of per-tile (h*p) partial outputs into one group result, then adds the group's x*D vector.
- Emits y_final under a full valid/ready handshake.
- Successor to the fixed-TILES_PER_GROUP, no-backpressure group accumulator. Adds:
  - runtime group length
  - queued xD (several groups in flight)
  - output backpressure
  - saturation and overflow flagging
  - synchronous flush

---
 rtl/ssm_group_accum.sv | 215 +++++++++++++++++++++
 tb/tb_ssm_group_accum.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssm_group_accum.sv
// Group accumulator: sums n_grp per-tile partials per lane, adds a queued xD vector, emits y_final.
// Latency: last tile at cycle t with xD queued -> y_valid_o at t+2; n-tile group takes n+2 cycles.
// Backpressure: y_ready_i low holds the result in OUT and stalls tiles; xd_ready_o drops when the xD FIFO is full.

module ssm_group_accum_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW:0]   count;

    // pointer and occupancy tracking; push+pop together leaves occupancy unchanged
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // storage array, written only on accepted pushes
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);
endmodule

module ssm_group_accum #(
    parameter int DW        = 16,
    parameter int H_TILE    = 1,
    parameter int P_TILE    = 1,
    parameter int MAX_TILES = 16,
    parameter int ACC_GUARD = 4,
    parameter int XD_DEPTH  = 4,
    parameter int SAT       = 1,
    localparam int L        = H_TILE * P_TILE,
    localparam int CW       = $clog2(MAX_TILES + 1)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            clear_i,
    input  logic [CW-1:0]   cfg_tiles_i,
    input  logic            tile_valid_i,
    output logic            tile_ready_o,
    input  logic [L*DW-1:0] tile_data_i,
    input  logic            xd_valid_i,
    output logic            xd_ready_o,
    input  logic [L*DW-1:0] xd_data_i,
    output logic            y_valid_o,
    input  logic            y_ready_i,
    output logic [L*DW-1:0] y_data_o,
    output logic            ovf_o,
    output logic [15:0]     group_cnt_o
);
    localparam int AW = DW + ACC_GUARD;
    localparam logic [DW-1:0] Y_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] Y_MIN = {1'b1, {(DW-1){1'b0}}};

    if (MAX_TILES > (1 << ACC_GUARD)) begin : g_guard_chk
        $error("MAX_TILES exceeds the range covered by ACC_GUARD");
    end
    if (XD_DEPTH < 2 || (XD_DEPTH & (XD_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("XD_DEPTH must be a power of two and at least 2");
    end

    typedef enum logic [1:0] {ACCUM, FINAL, OUT} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          n_grp;
    logic signed [AW-1:0]   acc [L];
    logic signed [AW:0]     sum [L];
    logic [L-1:0]           in_rng;
    logic [L*DW-1:0]        y_nxt;
    logic                   ovf_nxt;
    logic                   pop;
    logic                   push;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [L*DW-1:0]        xd_head;
    logic                   tile_fire;
    logic                   last_tile;
    logic [CW-1:0]          cfg_eff;
    logic [CW-1:0]          n_cur;

    // a zero tile count means a single-tile group; count is latched on the first tile only
    assign cfg_eff   = (cfg_tiles_i == '0) ? CW'(1) : cfg_tiles_i;
    assign n_cur     = (cnt == '0) ? cfg_eff : n_grp;
    assign tile_fire = tile_valid_i && tile_ready_o;
    assign last_tile = tile_fire && ((cnt + CW'(1)) == n_cur);

    assign xd_ready_o = !fifo_full;
    assign push       = xd_valid_i && !fifo_full && !clear_i;
    assign y_valid_o  = (state == OUT);

    ssm_group_accum_fifo #(.W(L*DW), .DEPTH(XD_DEPTH)) u_xd_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .clear (clear_i),
        .push  (push),
        .pop   (pop),
        .wdata (xd_data_i),
        .rdata (xd_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        state <= ACCUM;
        else if (clear_i) state <= ACCUM;
        else              state <= state_nxt;
    end

    // next-state, tile acceptance and xD pop
    always_comb begin
        state_nxt    = state;
        tile_ready_o = 1'b0;
        pop          = 1'b0;
        case (state)
            ACCUM: begin
                tile_ready_o = 1'b1;
                if (last_tile) state_nxt = FINAL;
            end
            FINAL: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (y_ready_i) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
        if (clear_i) pop = 1'b0;
    end

    // skip-add per lane with saturate-or-wrap and out-of-range detection
    always_comb begin
        y_nxt   = '0;
        ovf_nxt = 1'b0;
        in_rng  = '0;
        for (int k = 0; k < L; k++) begin
            sum[k]    = (AW+1)'(acc[k]) + (AW+1)'($signed(xd_head[DW*(k+1)-1 -: DW]));
            in_rng[k] = (&sum[k][AW:DW-1]) | ~(|sum[k][AW:DW-1]);
            y_nxt[DW*(k+1)-1 -: DW] = sum[k][DW-1:0];
            if (!in_rng[k]) begin
                ovf_nxt = 1'b1;
                if (SAT != 0) y_nxt[DW*(k+1)-1 -: DW] = sum[k][AW] ? Y_MIN : Y_MAX;
            end
        end
    end

    // tile accumulation, result capture and sticky overflow
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt      <= '0;
            n_grp    <= CW'(1);
            y_data_o <= '0;
            ovf_o    <= 1'b0;
            for (int k = 0; k < L; k++) acc[k] <= '0;
        end else if (clear_i) begin
            cnt   <= '0;
            ovf_o <= 1'b0;
            for (int k = 0; k < L; k++) acc[k] <= '0;
        end else begin
            if (tile_fire) begin
                for (int k = 0; k < L; k++) begin
                    if (cnt == '0) acc[k] <= AW'($signed(tile_data_i[DW*(k+1)-1 -: DW]));
                    else           acc[k] <= acc[k] + AW'($signed(tile_data_i[DW*(k+1)-1 -: DW]));
                end
                if (cnt == '0) n_grp <= cfg_eff;
                cnt <= last_tile ? '0 : cnt + 1'b1;
            end
            if (pop) begin
                y_data_o <= y_nxt;
                if (ovf_nxt) ovf_o <= 1'b1;
            end
        end
    end

    // delivered-group counter; survives flush, wraps naturally
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                       group_cnt_o <= '0;
        else if (!clear_i && state == OUT && y_ready_i)  group_cnt_o <= group_cnt_o + 1'b1;
    end
endmodule

// File: tb/tb_ssm_group_accum.sv
// Directed bench for ssm_group_accum with two lanes; a second instance runs in wrap mode.
// Inputs are driven 1 time unit after the rising edge, outputs sampled at that same point.
// Each scenario task performs its own comparisons.

module tb_ssm_group_accum;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        clear = 1'b0;
    logic [4:0]  cfg = 5'd1;
    logic        tile_valid = 1'b0;
    logic [31:0] tile_data = '0;
    logic        xd_valid = 1'b0;
    logic [31:0] xd_data = '0;
    logic        y_ready = 1'b0;

    logic        tile_ready, xd_ready, y_valid, ovf;
    logic [31:0] y_data;
    logic [15:0] group_cnt;
    logic        w_tile_ready, w_xd_ready, w_y_valid, w_ovf;
    logic [31:0] w_y_data;
    logic [15:0] w_group_cnt;

    int total = 0;
    int bad = 0;
    int exp_gcnt = 0;

    always #5 clk = ~clk;

    ssm_group_accum #(.DW(16), .H_TILE(1), .P_TILE(2), .MAX_TILES(16), .ACC_GUARD(4),
                      .XD_DEPTH(4), .SAT(1)) dut (
        .clk(clk), .rstn(rstn), .clear_i(clear), .cfg_tiles_i(cfg),
        .tile_valid_i(tile_valid), .tile_ready_o(tile_ready), .tile_data_i(tile_data),
        .xd_valid_i(xd_valid), .xd_ready_o(xd_ready), .xd_data_i(xd_data),
        .y_valid_o(y_valid), .y_ready_i(y_ready), .y_data_o(y_data),
        .ovf_o(ovf), .group_cnt_o(group_cnt));

    ssm_group_accum #(.DW(16), .H_TILE(1), .P_TILE(2), .MAX_TILES(16), .ACC_GUARD(4),
                      .XD_DEPTH(4), .SAT(0)) dut_wrap (
        .clk(clk), .rstn(rstn), .clear_i(clear), .cfg_tiles_i(cfg),
        .tile_valid_i(tile_valid), .tile_ready_o(w_tile_ready), .tile_data_i(tile_data),
        .xd_valid_i(xd_valid), .xd_ready_o(w_xd_ready), .xd_data_i(xd_data),
        .y_valid_o(w_y_valid), .y_ready_i(y_ready), .y_data_o(w_y_data),
        .ovf_o(w_ovf), .group_cnt_o(w_group_cnt));

    function automatic logic [31:0] pack(input logic signed [15:0] a, input logic signed [15:0] b);
        return {b, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic push_xd(input logic signed [15:0] a, input logic signed [15:0] b);
        xd_valid = 1'b1;
        xd_data  = pack(a, b);
        tick();
        xd_valid = 1'b0;
    endtask

    task automatic send_tile(input logic signed [15:0] a, input logic signed [15:0] b);
        tile_valid = 1'b1;
        tile_data  = pack(a, b);
        tick();
        tile_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        total++;
        if ({y_valid, ovf, tile_ready, xd_ready} !== 4'b0011) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=0011", {y_valid, ovf, tile_ready, xd_ready});
        end
        total++;
        if (y_data !== 32'h0 || group_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_data got y=%h cnt=%0d exp y=0 cnt=0", y_data, group_cnt);
        end
    endtask

    task automatic test_basic();
        do_clear();
        y_ready = 1'b1;
        cfg = 5'd3;
        push_xd(5, -5);
        send_tile(1, 2);
        send_tile(10, 20);
        send_tile(100, 200);
        total++;
        if (y_valid !== 1'b0 || tile_ready !== 1'b0) begin
            bad++;
            $display("FAIL basic_t1 got valid=%b tready=%b exp 0 0", y_valid, tile_ready);
        end
        tick();
        total++;
        if (y_valid !== 1'b1 || y_data !== pack(116, 217)) begin
            bad++;
            $display("FAIL basic_y got valid=%b y=%h exp 1 %h", y_valid, y_data, pack(116, 217));
        end
        tick();
        exp_gcnt++;
        total++;
        if (y_valid !== 1'b0 || group_cnt !== 16'(exp_gcnt)) begin
            bad++;
            $display("FAIL basic_done got valid=%b cnt=%0d exp 0 %0d", y_valid, group_cnt, exp_gcnt);
        end
    endtask

    task automatic test_runtime_len();
        do_clear();
        y_ready = 1'b1;
        cfg = 5'd1;
        push_xd(1, 1);
        push_xd(1, 1);
        send_tile(7, 7);
        tick();
        total++;
        if (y_valid !== 1'b1 || y_data !== pack(8, 8)) begin
            bad++;
            $display("FAIL len_g1 got valid=%b y=%h exp 1 %h", y_valid, y_data, pack(8, 8));
        end
        tick();
        exp_gcnt++;
        send_tile(7, 7);
        cfg = 5'd4;
        tick();
        total++;
        if (y_valid !== 1'b1 || y_data !== pack(8, 8)) begin
            bad++;
            $display("FAIL len_g2 got valid=%b y=%h exp 1 %h", y_valid, y_data, pack(8, 8));
        end
        tick();
        exp_gcnt++;
        push_xd(0, 0);
        send_tile(1, 1);
        cfg = 5'd1;
        send_tile(1, 1);
        send_tile(1, 1);
        total++;
        if (tile_ready !== 1'b1 || y_valid !== 1'b0) begin
            bad++;
            $display("FAIL len_g3_mid got tready=%b valid=%b exp 1 0", tile_ready, y_valid);
        end
        send_tile(1, 1);
        total++;
        if (tile_ready !== 1'b0) begin
            bad++;
            $display("FAIL len_g3_end got tready=%b exp 0", tile_ready);
        end
        tick();
        total++;
        if (y_valid !== 1'b1 || y_data !== pack(4, 4)) begin
            bad++;
            $display("FAIL len_g3_y got valid=%b y=%h exp 1 %h", y_valid, y_data, pack(4, 4));
        end
        tick();
        exp_gcnt++;
        total++;
        if (group_cnt !== 16'(exp_gcnt)) begin
            bad++;
            $display("FAIL len_cnt got=%0d exp=%0d", group_cnt, exp_gcnt);
        end
    endtask

    task automatic test_late_xd_backpressure();
        logic [31:0] held;
        do_clear();
        cfg = 5'd2;
        y_ready = 1'b0;
        send_tile(3, 4);
        send_tile(5, 6);
        tile_valid = 1'b1;
        tile_data  = pack(999, 999);
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (y_valid !== 1'b0 || tile_ready !== 1'b0) begin
                bad++;
                $display("FAIL late_wait%0d got valid=%b tready=%b exp 0 0", i, y_valid, tile_ready);
            end
        end
        push_xd(1, -1);
        total++;
        if (y_valid !== 1'b0) begin
            bad++;
            $display("FAIL late_push got valid=%b exp 0", y_valid);
        end
        tick();
        held = y_data;
        total++;
        if (y_valid !== 1'b1 || y_data !== pack(9, 9)) begin
            bad++;
            $display("FAIL late_y got valid=%b y=%h exp 1 %h", y_valid, y_data, pack(9, 9));
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (y_valid !== 1'b1 || y_data !== pack(9, 9) || tile_ready !== 1'b0) begin
                bad++;
                $display("FAIL late_hold%0d got valid=%b y=%h (first %h) tready=%b exp 1 %h 0",
                         i, y_valid, y_data, held, tile_ready, pack(9, 9));
            end
        end
        tile_valid = 1'b0;
        y_ready = 1'b1;
        tick();
        exp_gcnt++;
        total++;
        if (y_valid !== 1'b0 || group_cnt !== 16'(exp_gcnt)) begin
            bad++;
            $display("FAIL late_done got valid=%b cnt=%0d exp 0 %0d", y_valid, group_cnt, exp_gcnt);
        end
    endtask

    task automatic test_saturation();
        do_clear();
        cfg = 5'd2;
        y_ready = 1'b1;
        push_xd(0, 0);
        send_tile(30000, -30000);
        send_tile(30000, -30000);
        tick();
        total++;
        if (y_valid !== 1'b1 || y_data !== pack(32767, -32768) || ovf !== 1'b1) begin
            bad++;
            $display("FAIL sat_clamp got valid=%b y=%h ovf=%b exp 1 %h 1",
                     y_valid, y_data, ovf, pack(32767, -32768));
        end
        total++;
        if (w_y_data !== pack(-5536, 5536) || w_ovf !== 1'b1) begin
            bad++;
            $display("FAIL sat_wrap got y=%h ovf=%b exp %h 1", w_y_data, w_ovf, pack(-5536, 5536));
        end
        tick();
        exp_gcnt++;
    endtask

    task automatic test_fifo_full();
        do_clear();
        cfg = 5'd1;
        y_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_xd(16'(10 + 20 * i), 16'(20 + 20 * i));
            if (i == 2) begin
                total++;
                if (xd_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL full_3rd got xd_ready=%b exp 1", xd_ready);
                end
            end
        end
        total++;
        if (xd_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_4th got xd_ready=%b exp 0", xd_ready);
        end
        xd_valid = 1'b1;
        xd_data  = pack(555, 555);
        send_tile(2, 3);
        total++;
        if (xd_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_final got xd_ready=%b exp 0", xd_ready);
        end
        tick();
        xd_valid = 1'b0;
        total++;
        if (xd_ready !== 1'b1 || y_data !== pack(12, 23)) begin
            bad++;
            $display("FAIL full_pop got xd_ready=%b y=%h exp 1 %h", xd_ready, y_data, pack(12, 23));
        end
        tick();
        exp_gcnt++;
        send_tile(0, 0);
        tick();
        total++;
        if (y_valid !== 1'b1 || y_data !== pack(30, 40)) begin
            bad++;
            $display("FAIL full_order got valid=%b y=%h exp 1 %h", y_valid, y_data, pack(30, 40));
        end
        tick();
        exp_gcnt++;
    endtask

    task automatic test_flush();
        do_clear();
        cfg = 5'd1;
        y_ready = 1'b0;
        push_xd(32767, 0);
        push_xd(1, 1);
        push_xd(1, 1);
        send_tile(1, 0);
        tick();
        total++;
        if (y_valid !== 1'b1 || ovf !== 1'b1) begin
            bad++;
            $display("FAIL flush_pre got valid=%b ovf=%b exp 1 1", y_valid, ovf);
        end
        clear = 1'b1;
        y_ready = 1'b1;
        tick();
        clear = 1'b0;
        total++;
        if (y_valid !== 1'b0 || ovf !== 1'b0 || tile_ready !== 1'b1 || xd_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_state got valid=%b ovf=%b tready=%b xready=%b exp 0 0 1 1",
                     y_valid, ovf, tile_ready, xd_ready);
        end
        total++;
        if (group_cnt !== 16'(exp_gcnt)) begin
            bad++;
            $display("FAIL flush_cnt got=%0d exp=%0d", group_cnt, exp_gcnt);
        end
        cfg = 5'd2;
        send_tile(4, 5);
        send_tile(10, 10);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (y_valid !== 1'b0) begin
                bad++;
                $display("FAIL flush_empty%0d got valid=%b exp 0", i, y_valid);
            end
        end
        push_xd(2, 2);
        tick();
        total++;
        if (y_valid !== 1'b1 || y_data !== pack(16, 17) || ovf !== 1'b0) begin
            bad++;
            $display("FAIL flush_fresh got valid=%b y=%h ovf=%b exp 1 %h 0",
                     y_valid, y_data, ovf, pack(16, 17));
        end
        tick();
        exp_gcnt++;
        total++;
        if (group_cnt !== 16'(exp_gcnt)) begin
            bad++;
            $display("FAIL flush_cnt_after got=%0d exp=%0d", group_cnt, exp_gcnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_runtime_len();
        test_late_xd_backpressure();
        test_saturation();
        test_fifo_full();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
